// File: rtl/control_unit.sv
// Instruction-sequencing front end: 128x16 program ROM, PC, IR and the main control FSM.
// Optional macro CU_STATE_DEBUG_EN exports the FSM state codes on outState/nextState.
module control_unit (
   input  logic        Clk,
   input  logic        Reset,
   output logic [15:0] IR_Out,
   output logic [6:0]  PC_Out,
   output logic [7:0]  D_Addr,
   output logic        D_Wr,
   output logic        RF_s,
   output logic [3:0]  RF_W_Addr,
   output logic        RF_W_en,
   output logic [3:0]  RF_Ra_Addr,
   output logic [3:0]  RF_Rb_Addr,
   output logic [2:0]  ALU_s0,
   output logic [3:0]  outState,
   output logic [3:0]  nextState
);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOADA  = 4'd4,
      S_LOADB  = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_HALT   = 4'd8,
      S_SUB    = 4'd9
   } state_t;

   typedef struct packed {
      logic [7:0] d_addr;
      logic       d_wr;
      logic       rf_s;
      logic [3:0] w_addr;
      logic       w_en;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [2:0] alu;
      logic       pc_clr;
      logic       pc_up;
      logic       ir_ld;
   } ctrl_t;

   state_t      state_q, state_d;
   logic [6:0]  pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] rom_q;
   ctrl_t       ctrl_q;

   // Program image; unlisted locations read as NOOP.
   function automatic logic [15:0] rom_word(input logic [6:0] addr);
      case (addr)
         7'd0:    rom_word = 16'h3ABC;
         7'd1:    rom_word = 16'h4ABC;
         7'd2:    rom_word = 16'h2BCD;
         7'd3:    rom_word = 16'h1ABC;
         7'd4:    rom_word = 16'h0000;
         7'd5:    rom_word = 16'h5000;
         7'd6:    rom_word = 16'h1ABC;
         default: rom_word = 16'h0000;
      endcase
   endfunction

   function automatic ctrl_t ctrl_of(input state_t s, input logic [15:0] ir);
      ctrl_t c;
      c = '0;
      case (s)
         S_INIT:  c.pc_clr = 1'b1;
         S_FETCH: begin
            c.ir_ld = 1'b1;
            c.pc_up = 1'b1;
         end
         S_LOADA, S_LOADB: begin
            c.d_addr = ir[11:4];
            c.rf_s   = 1'b1;
            c.w_addr = ir[3:0];
            c.w_en   = (s == S_LOADB);
         end
         S_STORE: begin
            c.d_addr = ir[7:0];
            c.ra     = ir[11:8];
            c.d_wr   = 1'b1;
         end
         S_ADD, S_SUB: begin
            c.ra     = ir[11:8];
            c.rb     = ir[7:4];
            c.w_addr = ir[3:0];
            c.w_en   = 1'b1;
            c.alu    = (s == S_ADD) ? 3'b001 : 3'b010;
         end
         default: ;
      endcase
      return c;
   endfunction

   assign rom_q = rom_word(pc_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (ir_q[15:12])
               4'h1:    state_d = S_STORE;
               4'h2:    state_d = S_LOADA;
               4'h3:    state_d = S_ADD;
               4'h4:    state_d = S_SUB;
               4'h5:    state_d = S_HALT;
               default: state_d = S_NOOP;
            endcase
         end
         S_LOADA:  state_d = S_LOADB;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (ctrl_q.pc_clr)
         pc_d = 7'd0;
      else if (ctrl_q.pc_up)
         pc_d = pc_q + 7'd1;
      ir_d = ctrl_q.ir_ld ? rom_q : ir_q;
   end

   // Control lines are registered from the next state/IR so they stay Moore with the state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_INIT;
         pc_q    <= 7'd0;
         ir_q    <= 16'h0000;
         ctrl_q  <= ctrl_of(S_INIT, 16'h0000);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ctrl_q  <= ctrl_of(state_d, ir_d);
      end
   end

   assign IR_Out     = ir_q;
   assign PC_Out     = pc_q;
   assign D_Addr     = ctrl_q.d_addr;
   assign D_Wr       = ctrl_q.d_wr;
   assign RF_s       = ctrl_q.rf_s;
   assign RF_W_Addr  = ctrl_q.w_addr;
   assign RF_W_en    = ctrl_q.w_en;
   assign RF_Ra_Addr = ctrl_q.ra;
   assign RF_Rb_Addr = ctrl_q.rb;
   assign ALU_s0     = ctrl_q.alu;

`ifdef CU_STATE_DEBUG_EN
   assign outState  = state_q;
   assign nextState = state_d;
`else
   assign outState  = 4'd0;
   assign nextState = 4'd0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level model predicts every cycle's outputs
// under directed and randomly placed resets; a monitor compares on the falling edge.
module tb_control_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] IR_Out;
   logic [6:0]  PC_Out;
   logic [7:0]  D_Addr;
   logic        D_Wr;
   logic        RF_s;
   logic [3:0]  RF_W_Addr;
   logic        RF_W_en;
   logic [3:0]  RF_Ra_Addr;
   logic [3:0]  RF_Rb_Addr;
   logic [2:0]  ALU_s0;
   logic [3:0]  outState;
   logic [3:0]  nextState;

   control_unit dut (
      .Clk(Clk), .Reset(Reset), .IR_Out(IR_Out), .PC_Out(PC_Out),
      .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_Addr(RF_W_Addr),
      .RF_W_en(RF_W_en), .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr),
      .ALU_s0(ALU_s0), .outState(outState), .nextState(nextState)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [3:0]  st;
      logic [3:0]  nx;
      logic [6:0]  pc;
      logic [15:0] ir;
      logic [7:0]  da;
      logic        wr;
      logic        rfs;
      logic [3:0]  wa;
      logic        we;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [2:0]  alu;
   } rec_t;

   rec_t        expq[$];
   rec_t        plan[$];
   logic [15:0] prog [128];
   logic [6:0]  m_pc;
   logic [15:0] m_ir;
   bit          m_halt;
   int          last_st;
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;

   // Expected outputs of one cycle, from the state and the instruction being executed.
   function automatic rec_t mk(input int st, input int nx);
      rec_t e;
      e = '0;
      e.st = st[3:0];
      e.nx = nx[3:0];
      e.pc = m_pc;
      e.ir = m_ir;
      if (st == 4 || st == 5) begin
         e.da = m_ir[11:4]; e.rfs = 1'b1; e.wa = m_ir[3:0]; e.we = (st == 5);
      end else if (st == 6) begin
         e.da = m_ir[7:0]; e.ra = m_ir[11:8]; e.wr = 1'b1;
      end else if (st == 7 || st == 9) begin
         e.ra = m_ir[11:8]; e.rb = m_ir[7:4]; e.wa = m_ir[3:0]; e.we = 1'b1;
         e.alu = (st == 7) ? 3'b001 : 3'b010;
      end
      return e;
   endfunction

   // Plan every cycle of the next instruction: fetch, decode, then its execute cycles.
   task automatic gen_instr();
      int op, ex;
      if (m_halt) begin
         plan.push_back(mk(8, 8));
         return;
      end
      plan.push_back(mk(1, 2));
      m_ir = prog[m_pc];
      m_pc = m_pc + 7'd1;
      op = int'(m_ir[15:12]);
      case (op)
         1: ex = 6;
         2: ex = 4;
         3: ex = 7;
         4: ex = 9;
         5: ex = 8;
         default: ex = 3;
      endcase
      plan.push_back(mk(2, ex));
      if (op == 2) begin
         plan.push_back(mk(4, 5));
         plan.push_back(mk(5, 1));
      end else if (op == 5) begin
         m_halt = 1'b1;
         plan.push_back(mk(8, 8));
      end else begin
         plan.push_back(mk(ex, 1));
      end
   endtask

   task automatic model_step(input bit r);
      rec_t e;
      if (r) begin
         plan.delete();
         m_pc = 7'd0;
         m_ir = 16'h0000;
         m_halt = 1'b0;
         e = mk(0, 1);
      end else begin
         if (plan.size() == 0) gen_instr();
         e = plan.pop_front();
      end
      last_st = int'(e.st);
`ifndef CU_STATE_DEBUG_EN
      e.st = 4'd0;
      e.nx = 4'd0;
`endif
      expq.push_back(e);
   endtask

   task automatic step(input bit r);
      Reset = r;
      @(posedge Clk);
      model_step(r);
      @(negedge Clk);
   endtask

   initial begin
      rec_t e, a;
      forever begin
         @(negedge Clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {outState, nextState, PC_Out, IR_Out, D_Addr, D_Wr, RF_s, RF_W_Addr,
                 RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0};
            n_cmp++;
            if (a !== e) begin
               n_err++;
               $display("FAIL cyc%0d outputs: got st=%0d nx=%0d pc=%0d ir=%h da=%h wr=%b s=%b wa=%h we=%b ra=%h rb=%h alu=%b | want st=%0d nx=%0d pc=%0d ir=%h da=%h wr=%b s=%b wa=%h we=%b ra=%h rb=%h alu=%b",
                        cyc, a.st, a.nx, a.pc, a.ir, a.da, a.wr, a.rfs, a.wa, a.we, a.ra, a.rb, a.alu,
                        e.st, e.nx, e.pc, e.ir, e.da, e.wr, e.rfs, e.wa, e.we, e.ra, e.rb, e.alu);
            end
         end
         cyc++;
      end
   end

   initial begin
      int rst_left;
      int guard;
      for (int i = 0; i < 128; i++) prog[i] = 16'h0000;
      prog[0] = 16'h3ABC; prog[1] = 16'h4ABC; prog[2] = 16'h2BCD; prog[3] = 16'h1ABC;
      prog[4] = 16'h0000; prog[5] = 16'h5000; prog[6] = 16'h1ABC;
      m_pc = 7'd0; m_ir = 16'h0000; m_halt = 1'b0; last_st = 0;
      Reset = 1'b1;

      // Full program through HALT, then a long idle stretch in Halt.
      step(1); step(1);
      for (int i = 0; i < 30; i++) step(0);

      // Reset landing while the LOAD is in its first cycle.
      step(1);
      guard = 0;
      while (last_st != 4 && guard < 40) begin
         step(0);
         guard++;
      end
      step(1);
      for (int i = 0; i < 12; i++) step(0);

      // Randomly placed reset pulses of 1-3 cycles.
      rst_left = 0;
      for (int i = 0; i < 500; i++) begin
         if (rst_left > 0) begin
            rst_left--;
            step(1);
         end else if ($urandom_range(0, 24) == 0) begin
            rst_left = $urandom_range(0, 2);
            step(1);
         end else begin
            step(0);
         end
      end

      #1;
      if (expq.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected records left, want 0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing front end of the 16-bit processor: a 128×16 instruction memory, a 7-bit program counter, a 16-bit instruction register and the main control FSM. It fetches and decodes instructions and drives the data-memory and register-file/ALU control lines of the datapath. The current and next FSM state are exported for debug.

## Interface
- No parameters.
- Clk  in  1  rising-edge clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- IR_Out  out  16  instruction register contents.
- PC_Out  out  7  program counter / instruction-memory address.
- D_Addr  out  8  data-memory address.
- D_Wr  out  1  data-memory write enable.
- RF_s  out  1  register-file write-data select: 0 = ALU result, 1 = data memory.
- RF_W_Addr  out  4  register-file write address.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_Addr  out  4  register-file read port A address.
- RF_Rb_Addr  out  4  register-file read port B address.
- ALU_s0  out  3  ALU function: 000 pass/idle, 001 add, 010 subtract.
- outState  out  4  current FSM state code.
- nextState  out  4  combinational next FSM state code.

## Operation
- Instruction memory: 128×16 ROM, asynchronous read, `q = mem[PC_Out]`, contents loaded from the program init file; `Clk` port present but unused for reads.
- PC: clear has priority over increment; increments wrap from 127 to 0.
- IR: loads `q` when `IR_ld` is asserted, otherwise holds.
- Opcode is `IR[15:12]`: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6–F treated as NOOP.
- State codes: Init 0, Fetch 1, Decode 2, NoOp 3, LoadA 4, LoadB 5, Store 6, Add 7, Halt 8, Sub 9.
- State transitions:
  - Init→Fetch→Decode.
  - Decode→NoOp, Store, LoadA, Add, Sub or Halt by opcode.
  - LoadA→LoadB.
  - NoOp, LoadB, Store, Add and Sub→Fetch.
  - Halt→Halt until reset.
- Output defaults in every state: all addresses 0, D_Wr=0, RF_W_en=0, RF_s=0, ALU_s0=000, PC_clr=0, PC_up=0, IR_ld=0.
- Per-state outputs (only values that differ from the defaults):
  - Init: PC_clr=1.
  - Fetch: IR_ld=1, PC_up=1.
  - LoadA: D_Addr=IR[11:4], RF_s=1, RF_W_Addr=IR[3:0].
  - LoadB: as LoadA, plus RF_W_en=1.
  - Store: D_Addr=IR[7:0], RF_Ra_Addr=IR[11:8], D_Wr=1.
  - Add: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], RF_W_en=1, ALU_s0=001.
  - Sub: as Add, but ALU_s0=010.
  - Decode, NoOp, Halt: defaults only.

## Timing
- Reset sampled at a rising edge: state←Init, IR←0, PC←0. Reset mid-instruction aborts it; no partial write persists beyond the current cycle.
- While Reset is high: outState=0, nextState=1, all control outputs at their defaults, IR_Out=0, PC_Out=0.
- First Fetch is one cycle after Reset deasserts.
- At the Fetch→Decode edge: IR←mem[PC], and PC increments.
- Instruction latency from Fetch: 3 cycles for NOOP, ADD, SUB and STORE; 4 cycles for LOAD (A and B).
- Outputs are Moore (a function of state and IR only); nextState is combinational.
- HALT: PC and IR freeze, and no further fetches occur.

## Configuration
- `CU_STATE_DEBUG_EN`:
  - Defined: outState and nextState carry the state codes above.
  - Undefined: both are tied to 0 and the FSM is otherwise unchanged.
- All tests below assume the macro is defined.

## Test plan
ROM program for all scenarios: 3ABC, 4ABC, 2BCD, 1ABC, 0000, 5000, 1ABC.
- Reset 2 cycles, then release; 3 cycles later -> outState=7, nextState=1, ALU_s0=001, RF_s=0, RF_W_en=1, Ra=A, Rb=B, W=C.
- 3 more cycles -> outState=9, nextState=1, ALU_s0=010, RF_W_en=1.
- 3 more cycles -> LoadA: outState=4, nextState=5, RF_s=1, D_Addr=BC, W=D. Next cycle -> outState=5, nextState=1, RF_W_en=1.
- 3 more cycles -> Store: outState=6, D_Wr=1, D_Addr=BC, Ra=A, nextState=1. Then NOOP: outState=3, nextState=1.
- HALT is fetched; afterwards outState=8 and nextState=8 indefinitely, PC_Out stays 6, and the trailing STORE never executes.
- Assert Reset during LoadA -> next edge outState=0, PC_Out=0, IR_Out=0, RF_W_en=0.
